sram_host: RTL and testbench

SRAM_HOST -- requirements
Module: sram_host

---
 rtl/sram_host.sv | 173 +++++++++++++++++
 tb/tb_sram_host.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_host.sv
// Single-port SRAM host: accepts one read or write command at a time and
// sequences the SRAM request strobes for a fixed number of cycles each.

module sram_host #(
  parameter  int WIDTH  = 4,
  parameter  int DEPTH  = 32,
  parameter  int WR_LAT = 2,
  parameter  int RD_LAT = 2,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [WIDTH-1:0] cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             wr_req,
  output logic             re_req,
  output logic [AW-1:0]    addr_out,
  output logic [WIDTH-1:0] din_out,
  input  logic [WIDTH-1:0] dout_in,
  output logic             busy
);

  localparam int MAX_LAT = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
  localparam int CW      = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
  localparam logic [CW-1:0] WR_LAST = CW'(WR_LAT - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_cmd_ready;
  logic             r_busy;
  logic             r_wr_req;
  logic             r_re_req;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rdata;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_din;
  logic             w_accept;

  assign w_accept = r_cmd_ready & cmd_valid;

  // Command sequencer; every output is a register so nothing glitches toward the SRAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_req    <= 1'b0;
      r_re_req    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_addr      <= '0;
      r_din       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr      <= cmd_addr;
            r_din       <= cmd_wdata;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (cmd_we) begin
              r_state  <= S_WRITE;
              r_wr_req <= 1'b1;
            end else begin
              r_state  <= S_READ;
              r_re_req <= 1'b1;
            end
          end else begin
            // cmd_ready first rises on the edge after reset release
            r_cmd_ready <= 1'b1;
          end
        end
        S_WRITE: begin
          if (r_cnt == WR_LAST) begin
            r_state     <= S_IDLE;
            r_wr_req    <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_READ: begin
          if (r_cnt == RD_LAST) begin
            r_state     <= S_RESP;
            r_re_req    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rdata     <= dout_in;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
          end else begin
            r_rsp_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_cmd_ready <= 1'b0;
          r_busy      <= 1'b0;
          r_wr_req    <= 1'b0;
          r_re_req    <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign wr_req    = r_wr_req;
  assign re_req    = r_re_req;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign addr_out  = r_addr;
  assign din_out   = r_din;

  sram_host_checker u_checker (
    .clk       (clk),
    .rst       (rst),
    .cmd_ready (r_cmd_ready),
    .busy      (r_busy),
    .wr_req    (r_wr_req),
    .re_req    (r_re_req),
    .rsp_valid (r_rsp_valid)
  );

endmodule

// Protocol invariants of the host outputs.
module sram_host_checker (
  input logic clk,
  input logic rst,
  input logic cmd_ready,
  input logic busy,
  input logic wr_req,
  input logic re_req,
  input logic rsp_valid
);

  // Sample once per cycle while out of reset.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(wr_req && re_req)) else $error("wr_req and re_req both high");
      assert (!(cmd_ready && busy)) else $error("cmd_ready while busy");
      assert (!(rsp_valid && (wr_req || re_req))) else $error("request during response");
    end
  end

endmodule

// File: tb/tb_sram_host.sv
// Directed bench for sram_host with a transaction-level reference model and SRAM model.

module tb_sram_host;

  localparam int WIDTH  = 4;
  localparam int DEPTH  = 32;
  localparam int WR_LAT = 2;
  localparam int RD_LAT = 2;
  localparam int AW     = 5;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [AW-1:0]    cmd_addr;
  logic [WIDTH-1:0] cmd_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             wr_req;
  logic             re_req;
  logic [AW-1:0]    addr_out;
  logic [WIDTH-1:0] din_out;
  logic [WIDTH-1:0] dout_in;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  sram_host #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WR_LAT(WR_LAT), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .wr_req    (wr_req),
    .re_req    (re_req),
    .addr_out  (addr_out),
    .din_out   (din_out),
    .dout_in   (dout_in),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM behaviour seen by the host
  logic [WIDTH-1:0] sram [DEPTH];
  always @(posedge clk) if (wr_req) sram[addr_out] <= din_out;
  assign dout_in = re_req ? sram[addr_out] : 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a transaction in flight and its age in cycles since acceptance.
  localparam int M_IDLE = 0;
  localparam int M_WR   = 1;
  localparam int M_RD   = 2;
  int               m_mode;
  int               m_age;
  logic             m_armed;
  logic [AW-1:0]    e_addr;
  logic [WIDTH-1:0] e_din;
  logic [WIDTH-1:0] e_rdata;
  logic [WIDTH-1:0] s_mem [DEPTH];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode  <= M_IDLE;
      m_age   <= 0;
      m_armed <= 1'b0;
      e_addr  <= '0;
      e_din   <= '0;
      e_rdata <= '0;
    end else begin
      m_armed <= 1'b1;
      if (m_mode == M_IDLE) begin
        if (m_armed && cmd_valid) begin
          m_mode <= cmd_we ? M_WR : M_RD;
          m_age  <= 1;
          e_addr <= cmd_addr;
          e_din  <= cmd_wdata;
          if (cmd_we) s_mem[cmd_addr] <= cmd_wdata;
        end
      end else if (m_mode == M_WR) begin
        if (m_age == WR_LAT) m_mode <= M_IDLE;
        else m_age <= m_age + 1;
      end else begin
        if (m_age == RD_LAT) e_rdata <= s_mem[e_addr];
        if (m_age > RD_LAT && rsp_ready) m_mode <= M_IDLE;
        else m_age <= m_age + 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    chk("cmd_ready", cmd_ready, m_armed && m_mode == M_IDLE);
    chk("busy", busy, m_mode != M_IDLE);
    chk("wr_req", wr_req, m_mode == M_WR);
    chk("re_req", re_req, m_mode == M_RD && m_age <= RD_LAT);
    chk("rsp_valid", rsp_valid, m_mode == M_RD && m_age > RD_LAT);
    chk("addr_out", addr_out, e_addr);
    chk("din_out", din_out, e_din);
    chk("rsp_rdata", rsp_rdata, e_rdata);
  end

  // Present a command at a falling edge; return one cycle after the accepting edge.
  task automatic do_cmd(input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d, output int t);
    int n;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("cmd_accept_timeout", cmd_ready, 1'b1);
    t = cyc;
    @(negedge clk);
  endtask

  logic [AW-1:0]    tbl_addr [4];
  logic [WIDTH-1:0] tbl_data [4];

  initial begin
    int ta;
    int tb;
    int tc;
    tbl_addr[0] = 5'd1;  tbl_data[0] = 4'h1;
    tbl_addr[1] = 5'd2;  tbl_data[1] = 4'hE;
    tbl_addr[2] = 5'd30; tbl_data[2] = 4'h8;
    tbl_addr[3] = 5'd16; tbl_data[3] = 4'h7;
    rst = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_addr_out", addr_out, 5'd0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1'b1);

    // write 5 <- 0xA
    do_cmd(1'b1, 5'd5, 4'hA, ta);
    cmd_valid = 1'b0;
    chk("wr_c1_wr_req", wr_req, 1'b1);
    chk("wr_c1_addr", addr_out, 5'd5);
    chk("wr_c1_din", din_out, 4'hA);
    chk("wr_c1_ready", cmd_ready, 1'b0);
    @(negedge clk);
    chk("wr_c2_wr_req", wr_req, 1'b1);
    @(negedge clk);
    chk("wr_c3_ready", cmd_ready, 1'b1);
    chk("wr_c3_wr_req", wr_req, 1'b0);

    // read 5
    do_cmd(1'b0, 5'd5, 4'h0, ta);
    cmd_valid = 1'b0;
    chk("rd_c1_re_req", re_req, 1'b1);
    chk("rd_c1_addr", addr_out, 5'd5);
    @(negedge clk);
    chk("rd_c2_re_req", re_req, 1'b1);
    @(negedge clk);
    chk("rd_c3_rsp_valid", rsp_valid, 1'b1);
    chk("rd_c3_rdata", rsp_rdata, 4'hA);
    chk("rd_c3_re_req", re_req, 1'b0);
    @(negedge clk);
    chk("rd_c4_ready", cmd_ready, 1'b1);

    // boundary addresses with backpressure on the response
    do_cmd(1'b1, 5'd31, 4'hF, ta);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    do_cmd(1'b1, 5'd0, 4'h3, ta);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rsp_ready = 1'b0;
    do_cmd(1'b0, 5'd31, 4'h0, ta);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rdata", rsp_rdata, 4'hF);
      chk("bp_cmd_ready", cmd_ready, 1'b0);
      @(negedge clk);
    end
    chk("bp_still_valid", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released_valid", rsp_valid, 1'b0);
    chk("bp_released_ready", cmd_ready, 1'b1);
    do_cmd(1'b0, 5'd0, 4'h0, ta);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("addr0_rdata", rsp_rdata, 4'h3);
    @(negedge clk);

    // cmd_valid held high across back-to-back commands
    do_cmd(1'b1, 5'd7, 4'h6, ta);
    do_cmd(1'b0, 5'd7, 4'h0, tb);
    do_cmd(1'b1, 5'd8, 4'h9, tc);
    cmd_valid = 1'b0;
    chk("b2b_write_spacing", tb - ta, WR_LAT + 1);
    chk("b2b_read_spacing", tc - tb, RD_LAT + 2);
    chk("b2b_read_data", rsp_rdata, 4'h6);
    repeat (2) @(negedge clk);
    do_cmd(1'b0, 5'd8, 4'h0, ta);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("b2b_addr8_rdata", rsp_rdata, 4'h9);
    @(negedge clk);

    // reset during the first READ cycle
    do_cmd(1'b0, 5'd5, 4'h0, ta);
    cmd_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrd_re_req", re_req, 1'b0);
    chk("midrd_busy", busy, 1'b0);
    chk("midrd_rsp_valid", rsp_valid, 1'b0);
    chk("midrd_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_reset_no_rsp", rsp_valid, 1'b0);
    end
    do_cmd(1'b0, 5'd5, 4'h0, ta);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_read", rsp_rdata, 4'hA);
    @(negedge clk);

    // table of write/read-back pairs
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b1, tbl_addr[i], tbl_data[i], ta);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      do_cmd(1'b0, tbl_addr[i], 4'h0, ta);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("tbl_rdata", rsp_rdata, tbl_data[i]);
      @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
